tmds_channel_decoder: RTL and testbench
=======================================

Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the TMDS transmit path: takes unaligned 10-bit parallel words from a deserializer, finds the symbol boundary by searching for TMDS control tokens, and decodes aligned symbols into 8-bit pixel data, two control bits and data-enable.
- One instance per TMDS data channel, in the clk_pixel domain, after the DDIO-in/deserializer stage and before video timing recovery.

Parameters:
- SEARCH_TIMEOUT, 16: cycles without a control token at the current offset before the offset advances.
- LOCK_TOKENS, 4: consecutive control tokens at one offset required to declare lock.
- LOSS_TIMEOUT, 4096: cycles without any control token while locked before lock is dropped.

Ports:
- clk_pixel  in  1  pixel clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_word  in  10  raw deserialized word; bit 0 is the earliest serial bit.
- data  out  8  decoded pixel byte.
- c  out  2  decoded control bits {C1,C0}.
- de  out  1  1 = data symbol, 0 = control period.
- locked  out  1  alignment lock flag.
- offset  out  4  current bit offset, 0..9.

Behaviour:
- Window: prev_word is the registered previous in_word; window = {in_word, prev_word}, 20 bits; aligned symbol = window[offset+9 : offset].
- Control tokens (symbol bits 9..0): 1101010100 → c=00; 0010101011 → c=01; 0101010100 → c=10; 1010101011 → c=11.
- Pipeline: stage 1 registers the aligned symbol and a token-match flag. Stage 2 registers data, c and de. Latency is 2 clk_pixel cycles from the in_word that completes a symbol to the outputs.
- Data decode for non-token symbols:
  - If w[9]=1, invert w[7:0] first.
  - d[0]=w[0].
  - For i=1..7: if w[8]=1, d[i]=w[i]^w[i-1]; otherwise d[i]=~(w[i]^w[i-1]).
  - de=1; c holds its last value.
- Token symbol: de=0, c=token value, data=0.
- FSM states:
  - SEARCH: tok_cnt counts consecutive tokens; timer counts cycles since the last token.
    - Token seen: tok_cnt++ and timer cleared.
    - Non-token: tok_cnt cleared.
    - tok_cnt reaches LOCK_TOKENS: go to LOCKED.
    - timer reaches SEARCH_TIMEOUT-1 with no token: offset advances (9 wraps to 0), timer and tok_cnt clear, and stage-1 contents are discarded (match flag forced 0 for 1 cycle).
  - LOCKED: offset frozen; timer clears on every token.
    - timer reaches LOSS_TIMEOUT-1: return to SEARCH with offset+1 (mod 10) and counters cleared.
- Simultaneous events: a token arriving in the same cycle the timer expires counts as a token; no advance occurs.
- While locked=0, outputs are forced to data=0, c=00, de=0, regardless of decode.
- locked changes on the same edge as the state register; output forcing uses the registered locked.
- Reset (reset_n=0 at a clock edge, including mid-lock):
  - Next edge: state=SEARCH, offset=0, counters=0, prev_word=0, pipeline flushed.
  - Outputs: data=0, c=00, de=0, locked=0.
- Widths: timer sized for max(SEARCH_TIMEOUT, LOSS_TIMEOUT); tok_cnt saturates at LOCK_TOKENS.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with random in_word → data=0x00, c=00, de=0, locked=0, offset=0 on every cycle.
- Lock at offset 0: stream symbol 0x354 (1101010100) each cycle → locked=1 after 4 tokens (≤8 cycles); outputs c=00, de=0; offset stays 0.
- Bit-slip: build in_word_n = {S_n[6:0], S_{n-1}[9:7]} from a stream of 0x354 symbols → offset steps 0→1→2→3 every 16 cycles; locked=1 at offset=3 within 60 cycles; c=00.
- Decode after lock: symbol 0x100 → data=0x00, de=1, 2 cycles after input. Symbol 0x2FF → data=0xFE, de=1. Symbol 0x0AB → c=01, de=0.
- Loss of lock: after lock, send 4096 consecutive data symbols 0x100 → locked drops to 0 on cycle 4096; offset increments by 1; outputs are forced to 0 on the next cycle. A single 0x354 at cycle 4000 instead keeps lock.
- Mid-lock reset: pulse reset_n=0 for 1 cycle while locked at offset 3 → locked=0 and offset=0 next cycle; relock at offset 3 follows per the bit-slip scenario.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: finds the 10-bit symbol boundary by hunting for control
// tokens, then decodes aligned symbols into pixel data, control bits and data-enable.
module tmds_channel_decoder #(
  parameter int unsigned SEARCH_TIMEOUT = 16,
  parameter int unsigned LOCK_TOKENS    = 4,
  parameter int unsigned LOSS_TIMEOUT   = 4096
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [9:0] in_word,
  output logic [7:0] data,
  output logic [1:0] c,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int unsigned TMR_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned TOK_W   = (LOCK_TOKENS > 0) ? $clog2(LOCK_TOKENS + 1) : 1;

  typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [3:0]       offset_q, offset_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TOK_W-1:0] tok_cnt_q, tok_cnt_d;
  logic             locked_q, locked_d;
  logic [9:0]       prev_word_q, prev_word_d;
  logic [9:0]       sym_q, sym_d;
  logic             match_q, match_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       c_q, c_d;
  logic             de_q, de_d;
  logic [18:0]      window_c;
  logic [9:0]       sym_c;
  logic             advance_c;

  function automatic logic is_token(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  function automatic logic [1:0] token_ctl(input logic [9:0] w);
    logic [1:0] r;
    case (w)
      10'h0AB: r = 2'b01;
      10'h154: r = 2'b10;
      10'h2AB: r = 2'b11;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] decode_data(input logic [9:0] w);
    logic [7:0] v;
    logic [7:0] d;
    v    = w[9] ? ~w[7:0] : w[7:0];
    d[0] = v[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = w[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
    end
    return d;
  endfunction

  // in_word[9] only matters once it has moved into prev_word; offset 9 tops out at bit 18
  always_comb begin
    window_c = {in_word[8:0], prev_word_q};
    case (offset_q)
      4'd1:    sym_c = window_c[10:1];
      4'd2:    sym_c = window_c[11:2];
      4'd3:    sym_c = window_c[12:3];
      4'd4:    sym_c = window_c[13:4];
      4'd5:    sym_c = window_c[14:5];
      4'd6:    sym_c = window_c[15:6];
      4'd7:    sym_c = window_c[16:7];
      4'd8:    sym_c = window_c[17:8];
      4'd9:    sym_c = window_c[18:9];
      default: sym_c = window_c[9:0];
    endcase
  end

  // alignment FSM, driven by the stage-1 token flag
  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    timer_d   = timer_q;
    tok_cnt_d = tok_cnt_q;
    advance_c = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (match_q) begin
          timer_d = '0;
          if (tok_cnt_q < TOK_W'(LOCK_TOKENS)) tok_cnt_d = tok_cnt_q + TOK_W'(1);
          if (tok_cnt_d == TOK_W'(LOCK_TOKENS)) state_d = ST_LOCKED;
        end else begin
          tok_cnt_d = '0;
          if (timer_q == TMR_W'(SEARCH_TIMEOUT - 1)) advance_c = 1'b1;
          else timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_LOCKED: begin
        if (match_q) begin
          timer_d = '0;
        end else if (timer_q == TMR_W'(LOSS_TIMEOUT - 1)) begin
          advance_c = 1'b1;
          state_d   = ST_SEARCH;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = ST_SEARCH;
    endcase
    if (advance_c) begin
      offset_d  = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
      timer_d   = '0;
      tok_cnt_d = '0;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // stage 1 drops its token flag on an offset change so stale alignment never counts
  always_comb begin
    prev_word_d = in_word;
    sym_d       = sym_c;
    match_d     = is_token(sym_c) && !advance_c;
  end

  always_comb begin
    data_d = '0;
    c_d    = c_q;
    de_d   = 1'b0;
    if (match_q) begin
      c_d = token_ctl(sym_q);
    end else begin
      data_d = decode_data(sym_q);
      de_d   = 1'b1;
    end
    if (!locked_q) begin
      data_d = '0;
      c_d    = '0;
      de_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state_q     <= ST_SEARCH;
      offset_q    <= '0;
      timer_q     <= '0;
      tok_cnt_q   <= '0;
      locked_q    <= 1'b0;
      prev_word_q <= '0;
      sym_q       <= '0;
      match_q     <= 1'b0;
      data_q      <= '0;
      c_q         <= '0;
      de_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      timer_q     <= timer_d;
      tok_cnt_q   <= tok_cnt_d;
      locked_q    <= locked_d;
      prev_word_q <= prev_word_d;
      sym_q       <= sym_d;
      match_q     <= match_d;
      data_q      <= data_d;
      c_q         <= c_d;
      de_q        <= de_d;
    end
  end

  assign data   = data_q;
  assign c      = c_q;
  assign de     = de_q;
  assign locked = locked_q;
  assign offset = offset_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: drivers queue cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_tmds_channel_decoder;

  logic       clk_pixel = 1'b0;
  logic       reset_n;
  logic [9:0] in_word;
  logic [7:0] data;
  logic [1:0] c;
  logic       de;
  logic       locked;
  logic [3:0] offset;

  tmds_channel_decoder dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .in_word   (in_word),
    .data      (data),
    .c         (c),
    .de        (de),
    .locked    (locked),
    .offset    (offset)
  );

  always #5 clk_pixel = ~clk_pixel;

  int cyc = 0;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  typedef struct {
    int         at;
    int         tag;
    logic [2:0] mask;
    logic [7:0] data;
    logic [1:0] c;
    logic       de;
    logic       locked;
    logic [3:0] offset;
  } exp_t;

  localparam logic [2:0] M_OUT  = 3'b001;
  localparam logic [2:0] M_LOCK = 3'b010;
  localparam logic [2:0] M_OFF  = 3'b100;
  localparam logic [2:0] M_ALL  = 3'b111;
  localparam logic [2:0] M_NONE = 3'b000;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [9:0] s_prev   = 10'h354;

  // directed decode vectors: symbol, expected data, c, de
  logic [9:0] b_sym [8] = '{10'h100, 10'h2FF, 10'h0AB, 10'h0F0, 10'h3C3, 10'h154, 10'h1B4, 10'h2AB};
  logic [7:0] b_dat [8] = '{8'h00,   8'hFE,   8'h00,   8'hEE,   8'h44,   8'h00,   8'hDC,   8'h00};
  logic [1:0] b_c   [8] = '{2'b00,   2'b00,   2'b01,   2'b01,   2'b01,   2'b10,   2'b10,   2'b11};
  logic       b_de  [8] = '{1'b1,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0,    1'b1,    1'b0};

  task automatic push_exp(input int at, input int tag, input logic [2:0] mask, input logic [7:0] d,
                          input logic [1:0] cc, input logic dd, input logic lk, input logic [3:0] off);
    exp_t e;
    int   i;
    e.at = at; e.tag = tag; e.mask = mask; e.data = d; e.c = cc; e.de = dd; e.locked = lk; e.offset = off;
    i = exp_q.size();
    while (i > 0 && exp_q[i-1].at > at) i--;
    exp_q.insert(i, e);
  endtask

  // the word driven now completes its symbol with the next word: output 3 edges later
  task automatic send_raw(input logic [9:0] w, input int tag, input logic [2:0] mask, input logic [7:0] d,
                          input logic [1:0] cc, input logic dd, input logic lk, input logic [3:0] off);
    in_word = w;
    if (mask != M_NONE) push_exp(cyc + 3, tag, mask, d, cc, dd, lk, off);
    @(negedge clk_pixel);
  endtask

  // symbol stream slipped by 3 bits: word = {S_n[6:0], S_n-1[9:7]}
  task automatic send_slip(input logic [9:0] s, input int tag, input logic [2:0] mask, input logic [7:0] d,
                           input logic [1:0] cc, input logic dd);
    in_word = {s[6:0], s_prev[9:7]};
    s_prev  = s;
    if (mask != M_NONE) push_exp(cyc + 3, tag, mask, d, cc, dd, 1'b1, 4'd3);
    @(negedge clk_pixel);
  endtask

  function automatic logic [3:0] slip_off(input int t, input int z);
    if (t < z + 16) return 4'd0;
    if (t < z + 32) return 4'd1;
    if (t < z + 48) return 4'd2;
    return 4'd3;
  endfunction

  // release reset at the current negedge and hunt through offsets 0..3 to lock
  task automatic slip_relock(input int tag);
    int z;
    z       = cyc;
    reset_n = 1'b1;
    for (int t = z + 1; t <= z + 54; t++)
      push_exp(t, tag, M_ALL, 8'h00, 2'b00, 1'b0, (t >= z + 53), slip_off(t, z));
    repeat (56) send_slip(10'h354, tag, M_NONE, 8'h00, 2'b00, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    logic ok;
    forever begin
      @(negedge clk_pixel);
      while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
        e  = exp_q.pop_front();
        ok = (e.at == cyc);
        if (e.mask[0] && ({data, c, de} !== {e.data, e.c, e.de})) ok = 1'b0;
        if (e.mask[1] && (locked !== e.locked)) ok = 1'b0;
        if (e.mask[2] && (offset !== e.offset)) ok = 1'b0;
        n_checks++;
        if (!ok) begin
          n_fail++;
          $display("FAIL chk_t%0d cyc=%0d(due %0d) mask=%b got data=%h c=%b de=%b locked=%b offset=%0d want data=%h c=%b de=%b locked=%b offset=%0d",
                   e.tag, cyc, e.at, e.mask, data, c, de, locked, offset, e.data, e.c, e.de, e.locked, e.offset);
        end
      end
    end
  end

  initial begin : stimulus
    int   z, d0, lk_at, loss_at, at;
    exp_t e;
    reset_n = 1'b0;
    in_word = 10'($urandom);
    for (int t = 1; t <= 3; t++) push_exp(t, 0, M_ALL, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0);
    repeat (2) begin
      @(negedge clk_pixel);
      in_word = 10'($urandom);
    end
    @(negedge clk_pixel);

    n_checks++;
    if ({data, c, de} !== 11'd0) begin
      n_fail++;
      $display("FAIL direct_reset_out data=%h c=%b de=%b", data, c, de);
    end
    n_checks++;
    if (locked !== 1'b0 || offset !== 4'd0) begin
      n_fail++;
      $display("FAIL direct_reset_lock locked=%b offset=%0d", locked, offset);
    end

    // lock at offset 0 on a steady 0x354 stream
    reset_n = 1'b1;
    z       = cyc;
    lk_at   = z + 6;
    for (int i = 0; i < 8; i++)
      send_raw(10'h354, 1, M_ALL, 8'h00, 2'b00, 1'b0, (cyc + 3 >= lk_at), 4'd0);

    n_checks++;
    if (locked !== 1'b1 || offset !== 4'd0) begin
      n_fail++;
      $display("FAIL direct_lock0 locked=%b offset=%0d", locked, offset);
    end

    // decode vectors while locked at offset 0
    for (int i = 0; i < 8; i++)
      send_raw(b_sym[i], 2, M_ALL, b_dat[i], b_c[i], b_de[i], 1'b1, 4'd0);

    // one token inside a long data run keeps lock
    for (int i = 0; i <= 4200; i++) begin
      if (i == 4000)     send_raw(10'h354, 3, M_ALL, 8'h00, 2'b00, 1'b0, 1'b1, 4'd0);
      else if (i < 4000) send_raw(10'h100, 3, M_ALL, 8'h00, 2'b11, 1'b1, 1'b1, 4'd0);
      else               send_raw(10'h100, 3, M_ALL, 8'h00, 2'b00, 1'b1, 1'b1, 4'd0);
    end

    // 4096 data symbols after the last token drop lock and advance the offset
    send_raw(10'h354, 4, M_ALL, 8'h00, 2'b00, 1'b0, 1'b1, 4'd0);
    d0      = cyc;
    loss_at = d0 + 4098;
    for (int i = 0; i < 4100; i++) begin
      at = cyc + 3;
      send_raw(10'h100, 4, M_ALL, 8'h00, 2'b00, (at <= loss_at), (at < loss_at), (at < loss_at) ? 4'd0 : 4'd1);
    end

    n_checks++;
    if (locked !== 1'b0 || offset !== 4'd1) begin
      n_fail++;
      $display("FAIL direct_loss locked=%b offset=%0d", locked, offset);
    end

    repeat (4) send_raw(10'h100, 4, M_NONE, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0);

    // reset pulse, then bit-slip hunt to offset 3 and decode there
    reset_n = 1'b0;
    push_exp(cyc + 1, 5, M_ALL, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0);
    send_raw(10'h100, 5, M_NONE, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0);
    slip_relock(5);

    n_checks++;
    if (locked !== 1'b1 || offset !== 4'd3) begin
      n_fail++;
      $display("FAIL direct_slip_lock locked=%b offset=%0d", locked, offset);
    end

    send_slip(10'h2FF, 6, M_ALL, 8'hFE, 2'b00, 1'b1);
    send_slip(10'h3C3, 6, M_ALL, 8'h44, 2'b00, 1'b1);
    send_slip(10'h0AB, 6, M_ALL, 8'h00, 2'b01, 1'b0);
    send_slip(10'h1B4, 6, M_ALL, 8'hDC, 2'b01, 1'b1);
    send_slip(10'h154, 6, M_ALL, 8'h00, 2'b10, 1'b0);
    send_slip(10'h354, 6, M_NONE, 8'h00, 2'b00, 1'b0);
    send_slip(10'h354, 6, M_NONE, 8'h00, 2'b00, 1'b0);
    push_exp(cyc + 1, 7, M_LOCK | M_OFF, 8'h00, 2'b00, 1'b0, 1'b1, 4'd3);
    send_slip(10'h354, 6, M_NONE, 8'h00, 2'b00, 1'b0);

    // mid-lock reset pulse, then relock at offset 3
    reset_n = 1'b0;
    push_exp(cyc + 1, 7, M_ALL, 8'h00, 2'b00, 1'b0, 1'b0, 4'd0);
    send_slip(10'h354, 7, M_NONE, 8'h00, 2'b00, 1'b0);
    slip_relock(8);

    n_checks++;
    if (locked !== 1'b1 || offset !== 4'd3) begin
      n_fail++;
      $display("FAIL direct_relock locked=%b offset=%0d", locked, offset);
    end

    send_slip(10'h100, 9, M_ALL, 8'h00, 2'b00, 1'b1);
    send_slip(10'h2FF, 9, M_ALL, 8'hFE, 2'b00, 1'b1);
    send_slip(10'h0AB, 9, M_ALL, 8'h00, 2'b01, 1'b0);
    repeat (3) send_slip(10'h354, 9, M_NONE, 8'h00, 2'b00, 1'b0);

    repeat (8) @(negedge clk_pixel);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL unchecked_t%0d due cyc %0d never compared (now %0d)", e.tag, e.at, cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
